// File: rtl/core_pkg.sv
// Shared types and sizes for the rename/commit register-tag machinery.
// Rename and preg_reclaim both import this so tag and RAT layouts stay in lockstep.
package core_pkg;
    localparam int NUM_PREG = 64;
    localparam int NUM_AREG = 32;
    localparam int PREG_W   = 6;
    localparam int AREG_W   = 5;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    typedef struct packed {
        logic  valid;
        areg_t rd;
        preg_t p_rd;
        preg_t p_old_rd;
    } commit_slot_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } reclaim_state_t;

    // Pregs 0..31 back the architectural state out of reset; 32..63 start free.
    localparam logic [NUM_PREG-1:0] RESET_POOL = 64'hFFFF_FFFF_0000_0000;
endpackage

// File: rtl/preg_reclaim_if.sv
// Rename/commit-to-reclaim bundle: alloc and commit slots in, free pool and retirement RAT out.
// No handshake: rename stalls on recover_busy instead of being backpressured.
interface preg_reclaim_if;
    import core_pkg::*;

    logic                       alloc1_valid;
    preg_t                      alloc1_preg;
    logic                       alloc2_valid;
    preg_t                      alloc2_preg;
    logic                       commit1_valid;
    areg_t                      commit1_rd;
    preg_t                      commit1_p_rd;
    preg_t                      commit1_p_old_rd;
    logic                       commit2_valid;
    areg_t                      commit2_rd;
    preg_t                      commit2_p_rd;
    preg_t                      commit2_p_old_rd;
    logic                       flush;
    logic [NUM_PREG-1:0]        free_pool;
    logic [6:0]                 free_count;
    logic [NUM_AREG*PREG_W-1:0] retire_rat;
    logic                       recover_busy;

    modport master (
        output alloc1_valid, alloc1_preg, alloc2_valid, alloc2_preg,
        output commit1_valid, commit1_rd, commit1_p_rd, commit1_p_old_rd,
        output commit2_valid, commit2_rd, commit2_p_rd, commit2_p_old_rd,
        output flush,
        input  free_pool, free_count, retire_rat, recover_busy
    );

    modport slave (
        input  alloc1_valid, alloc1_preg, alloc2_valid, alloc2_preg,
        input  commit1_valid, commit1_rd, commit1_p_rd, commit1_p_old_rd,
        input  commit2_valid, commit2_rd, commit2_p_rd, commit2_p_old_rd,
        input  flush,
        output free_pool, free_count, retire_rat, recover_busy
    );
endinterface

// File: rtl/preg_pool_rebuild.sv
// Marks every preg referenced by the retirement RAT as in use; combinational, zero latency.
module preg_pool_rebuild
    import core_pkg::*;
(
    input  preg_t [NUM_AREG-1:0] rat,
    output logic  [NUM_PREG-1:0] in_use
);
    always_comb begin
        in_use = '0;
        for (int i = 0; i < NUM_AREG; i++) begin
            in_use[rat[i]] = 1'b1;
        end
    end
endmodule

// File: rtl/preg_reclaim.sv
// Frees retiring p_old_rd tags, tracks the retirement RAT and rebuilds the pool after flush.
// All state updates land one cycle later; no backpressure, rename stalls while recover_busy.
module preg_reclaim
    import core_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    preg_reclaim_if.slave bus
);
    localparam logic [NUM_PREG-1:0] PREG0_MASK = {{(NUM_PREG-1){1'b0}}, 1'b1};

    reclaim_state_t        state_q, state_nxt;
    preg_t [NUM_AREG-1:0]  rat_q, rat_nxt;
    logic  [NUM_PREG-1:0]  pool_q, pool_nxt;
    logic  [NUM_PREG-1:0]  in_use, free_set, alloc_clr;
    logic  [6:0]           count;
    commit_slot_t          c1, c2;
    logic                  c1_wr, c2_wr;

    assign c1 = {bus.commit1_valid, bus.commit1_rd, bus.commit1_p_rd, bus.commit1_p_old_rd};
    assign c2 = {bus.commit2_valid, bus.commit2_rd, bus.commit2_p_rd, bus.commit2_p_old_rd};
    // Writes to r0 are architectural no-ops and must not leak a tag.
    assign c1_wr = c1.valid && (c1.rd != '0);
    assign c2_wr = c2.valid && (c2.rd != '0);

    preg_pool_rebuild u_rebuild (
        .rat    (rat_q),
        .in_use (in_use)
    );

    always_comb begin
        alloc_clr = '0;
        if (bus.alloc1_valid) alloc_clr[bus.alloc1_preg] = 1'b1;
        if (bus.alloc2_valid) alloc_clr[bus.alloc2_preg] = 1'b1;
    end

    always_comb begin
        free_set = '0;
        if (c1_wr) free_set[c1.p_old_rd] = 1'b1;
        if (c2_wr) free_set[c2.p_old_rd] = 1'b1;
        free_set = free_set & ~PREG0_MASK;
    end

    // Slot 2 is younger, so its write lands last and wins a same-rd collision.
    always_comb begin
        rat_nxt = rat_q;
        if (c1_wr) rat_nxt[c1.rd] = c1.p_rd;
        if (c2_wr) rat_nxt[c2.rd] = c2.p_rd;
    end

    always_comb begin
        pool_nxt = pool_q;
        case (state_q)
            ST_RUN:     pool_nxt = (bus.flush ? pool_q : (pool_q & ~alloc_clr)) | free_set;
            ST_RECOVER: pool_nxt = ~(in_use | PREG0_MASK) | free_set;
            default:    pool_nxt = pool_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_RUN:     state_nxt = bus.flush ? ST_RECOVER : ST_RUN;
            ST_RECOVER: state_nxt = bus.flush ? ST_RECOVER : ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        bus.recover_busy = (state_q == ST_RECOVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_AREG; i++) rat_q[i] <= preg_t'(i);
            pool_q <= RESET_POOL;
        end else begin
            rat_q  <= rat_nxt;
            pool_q <= pool_nxt;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_PREG; i++) count = count + {6'd0, pool_q[i]};
    end

    assign bus.free_pool  = pool_q;
    assign bus.free_count = count;
    assign bus.retire_rat = rat_q;

    // Rename must never hand out a tag that is being freed in the same cycle.
    a_no_alloc_free_overlap: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_RUN && !bus.flush) |-> ((alloc_clr & free_set) == '0));
endmodule

// File: tb/tb_preg_reclaim.sv
// Directed test-plan sequences then random traffic, scored against a behavioural model.
module tb_preg_reclaim;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    preg_reclaim_if bus ();

    preg_reclaim dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0]  pool;
        logic [6:0]   cnt;
        logic [191:0] rat;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Model state: committed map, free set, and whether a rebuild is pending.
    logic [5:0]  m_rat[32];
    logic [63:0] m_pool;
    bit          m_rec;

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit rst,
                       input bit a1v, input int a1p, input bit a2v, input int a2p,
                       input bit c1v, input int c1rd, input int c1p, input int c1o,
                       input bit c2v, input int c2rd, input int c2p, input int c2o,
                       input bit fl);
        logic [5:0]  nr[32];
        logic [63:0] np;
        logic [63:0] fr;
        exp_t        e;
        @(negedge clk);
        reset                = rst;
        bus.alloc1_valid     = a1v;  bus.alloc1_preg = 6'(a1p);
        bus.alloc2_valid     = a2v;  bus.alloc2_preg = 6'(a2p);
        bus.commit1_valid    = c1v;  bus.commit1_rd = 5'(c1rd);
        bus.commit1_p_rd     = 6'(c1p); bus.commit1_p_old_rd = 6'(c1o);
        bus.commit2_valid    = c2v;  bus.commit2_rd = 5'(c2rd);
        bus.commit2_p_rd     = 6'(c2p); bus.commit2_p_old_rd = 6'(c2o);
        bus.flush            = fl;

        if (rst) begin
            for (int i = 0; i < 32; i++) m_rat[i] = 6'(i);
            m_pool = 64'hFFFF_FFFF_0000_0000;
            m_rec  = 1'b0;
        end else begin
            nr = m_rat;
            fr = '0;
            if (c1v && c1rd != 0) begin nr[c1rd] = 6'(c1p); if (c1o != 0) fr[c1o] = 1'b1; end
            if (c2v && c2rd != 0) begin nr[c2rd] = 6'(c2p); if (c2o != 0) fr[c2o] = 1'b1; end
            if (!m_rec) begin
                np = m_pool;
                if (!fl) begin
                    if (a1v) np[a1p] = 1'b0;
                    if (a2v) np[a2p] = 1'b0;
                end
            end else begin
                for (int p = 0; p < 64; p++) begin
                    bit used = 1'b0;
                    for (int a = 0; a < 32; a++) if (m_rat[a] == 6'(p)) used = 1'b1;
                    np[p] = (p != 0) && !used;
                end
            end
            m_pool = np | fr;
            m_rat  = nr;
            m_rec  = fl;
        end

        e.pool = m_pool;
        e.cnt  = '0;
        for (int i = 0; i < 64; i++) e.cnt = e.cnt + 7'(m_pool[i]);
        for (int i = 0; i < 32; i++) e.rat[i*6 +: 6] = m_rat[i];
        e.busy = m_rec;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit rst);
        cyc(rst, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("free_pool",    192'(bus.free_pool),    192'(e.pool));
                check("free_count",   192'(bus.free_count),   192'(e.cnt));
                check("retire_rat",   bus.retire_rat,         e.rat);
                check("recover_busy", 192'(bus.recover_busy), 192'(e.busy));
            end
        end
    end

    initial begin : driver
        reset = 1'b1;
        bus.alloc1_valid = 0; bus.alloc1_preg = 0; bus.alloc2_valid = 0; bus.alloc2_preg = 0;
        bus.commit1_valid = 0; bus.commit1_rd = 0; bus.commit1_p_rd = 0; bus.commit1_p_old_rd = 0;
        bus.commit2_valid = 0; bus.commit2_rd = 0; bus.commit2_p_rd = 0; bus.commit2_p_old_rd = 0;
        bus.flush = 0;

        idle(1); idle(1); idle(0);
        // Alloc 32/33, then retire rd3 onto 32.
        cyc(0, 1,32,1,33, 0,0,0,0, 0,0,0,0, 0);
        cyc(0, 0,0,0,0, 1,3,32,3, 0,0,0,0, 0);
        idle(0);
        // Dual commit to rd7: younger slot owns the mapping.
        cyc(0, 0,0,0,0, 1,7,40,7, 1,7,41,40, 0);
        idle(0);
        // r0 commit is a no-op.
        cyc(0, 0,0,0,0, 1,0,0,0, 0,0,0,0, 0);
        idle(0);
        // Allocate 32..40, flush alongside a commit, let the rebuild happen.
        idle(1);
        for (int t = 32; t < 40; t += 2) cyc(0, 1,t,1,t+1, 0,0,0,0, 0,0,0,0, 0);
        cyc(0, 1,40,0,0, 0,0,0,0, 0,0,0,0, 0);
        cyc(0, 0,0,0,0, 1,1,32,1, 0,0,0,0, 1);
        idle(0); idle(0);
        // Flush held two cycles, alloc during RECOVER ignored.
        cyc(0, 1,50,0,0, 0,0,0,0, 0,0,0,0, 1);
        cyc(0, 1,51,1,52, 0,0,0,0, 0,0,0,0, 1);
        cyc(0, 1,53,0,0, 0,0,0,0, 0,0,0,0, 0);
        idle(0);
        // Reset while in RECOVER.
        cyc(0, 0,0,0,0, 1,4,45,4, 0,0,0,0, 1);
        cyc(1, 1,60,0,0, 1,5,46,5, 0,0,0,0, 1);
        idle(0);

        for (int n = 0; n < 800; n++) begin
            bit rst, fl, a1v, a2v, c1v, c2v;
            int a1p, a2p, c1rd, c1p, c1o, c2rd, c2p, c2o;
            rst  = ($urandom_range(0, 99) == 0);
            fl   = ($urandom_range(0, 9) == 0);
            a1v  = $urandom_range(0, 1) == 1;  a1p = $urandom_range(0, 63);
            a2v  = $urandom_range(0, 1) == 1;  a2p = $urandom_range(0, 63);
            c1v  = $urandom_range(0, 1) == 1;  c1rd = $urandom_range(0, 31);
            c1p  = $urandom_range(0, 63);
            c1o  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 63);
            c2v  = $urandom_range(0, 1) == 1;
            c2rd = ($urandom_range(0, 3) == 0) ? c1rd : $urandom_range(0, 31);
            c2p  = $urandom_range(0, 63);
            c2o  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 63);
            // Keep rename legal: never allocate a tag being freed this cycle.
            if ((c1v && c1rd != 0 && c1o != 0 && c1o == a1p) ||
                (c2v && c2rd != 0 && c2o != 0 && c2o == a1p)) a1v = 1'b0;
            if ((c1v && c1rd != 0 && c1o != 0 && c1o == a2p) ||
                (c2v && c2rd != 0 && c2o != 0 && c2o == a2p)) a2v = 1'b0;
            cyc(rst, a1v,a1p,a2v,a2p, c1v,c1rd,c1p,c1o, c2v,c2rd,c2p,c2o, fl);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
